// File: rtl/big_core_dmem_arb.sv
// Round-robin arbiter sharing the D_MEM data port between the core and the fabric/DMA requester.
// It rebases winning requests to D_MEM-local addresses and routes read data back through a latency-matched tag pipe.
package big_core_dmem_arb_pkg;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] wr_data;
        logic [3:0]  byte_en;
        logic        wr_en;
        logic        rd_en;
    } t_core2mem_req;

    typedef struct packed {
        logic valid;
        logic owner;
        logic oor;
    } t_rd_tag;

endpackage

module big_core_dmem_arb
    import big_core_dmem_arb_pkg::*;
#(
    parameter int unsigned RD_LATENCY   = 1,
    parameter logic [31:0] REGION_FLOOR = 32'h0001_0000,
    parameter logic [31:0] REGION_ROOF  = 32'h0001_FFFF
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        CoreReqValid,
    input  logic [69:0] CoreReq,
    output logic        CoreReqReady,
    output logic        CoreRspValid,
    output logic [31:0] CoreRspData,
    input  logic        FabReqValid,
    input  logic [69:0] FabReq,
    output logic        FabReqReady,
    output logic        FabRspValid,
    output logic [31:0] FabRspData,
    output logic [69:0] MemReq,
    input  logic [31:0] MemRdData,
    output logic        OorErr
);

    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_FAB  = 1'b1;

    typedef enum logic {
        PREF_CORE = 1'b0,
        PREF_FAB  = 1'b1
    } t_pref;

    t_pref         pref_q, pref_d;
    logic          oor_err_q, oor_err_d;
    t_rd_tag       tag_q [RD_LATENCY];
    t_rd_tag       tag_push;
    t_rd_tag       tag_out;

    t_core2mem_req core_req, fab_req, win_req, mem_req;
    logic          core_live, fab_live, core_win, fab_win, any_win, win_oor;

    // Arbitration and issue: contention goes to the requester that did not win last,
    // with the core favoured out of reset. Null requests are acked and dropped.
    always_comb begin
        core_req  = t_core2mem_req'(CoreReq);
        fab_req   = t_core2mem_req'(FabReq);
        core_live = CoreReqValid && (core_req.wr_en || core_req.rd_en);
        fab_live  = FabReqValid && (fab_req.wr_en || fab_req.rd_en);
        core_win  = core_live && (!fab_live || (pref_q == PREF_CORE));
        fab_win   = fab_live && !core_win;
        any_win   = core_win || fab_win;

        CoreReqReady = core_win || (CoreReqValid && !core_live);
        FabReqReady  = fab_win || (FabReqValid && !fab_live);

        win_req = fab_win ? fab_req : core_req;
        win_oor = (win_req.address < REGION_FLOOR) || (win_req.address > REGION_ROOF);

        mem_req = '0;
        if (any_win) begin
            mem_req         = win_req;
            mem_req.address = win_req.address - REGION_FLOOR;
            if (win_oor) begin
                mem_req.wr_en = 1'b0;
                mem_req.rd_en = 1'b0;
            end else if (win_req.wr_en) begin
                mem_req.rd_en = 1'b0;
            end
        end
        MemReq = 70'(mem_req);

        tag_push       = '0;
        tag_push.valid = any_win && win_req.rd_en && !win_req.wr_en;
        tag_push.owner = fab_win ? OWNER_FAB : OWNER_CORE;
        tag_push.oor   = win_oor;

        pref_d = pref_q;
        if (any_win) begin
            pref_d = fab_win ? PREF_CORE : PREF_FAB;
        end
        oor_err_d = oor_err_q || (any_win && win_oor);
    end

    // Read-data return: the oldest tag lines up with MemRdData for the issue it tracks.
    always_comb begin
        tag_out      = tag_q[RD_LATENCY-1];
        CoreRspValid = 1'b0;
        CoreRspData  = '0;
        FabRspValid  = 1'b0;
        FabRspData   = '0;
        if (tag_out.valid) begin
            if (tag_out.owner == OWNER_FAB) begin
                FabRspValid = 1'b1;
                FabRspData  = tag_out.oor ? 32'h0 : MemRdData;
            end else begin
                CoreRspValid = 1'b1;
                CoreRspData  = tag_out.oor ? 32'h0 : MemRdData;
            end
        end
    end

    assign OorErr = oor_err_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pref_q    <= PREF_CORE;
            oor_err_q <= 1'b0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            pref_q    <= pref_d;
            oor_err_q <= oor_err_d;
            tag_q[0]  <= tag_push;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_big_core_dmem_arb.sv
// Bench for big_core_dmem_arb: three instances (read latency 1, 2, 3) share one stimulus stream
// and are checked against a transaction-level model of grants, issue and response timing.
module tb_big_core_dmem_arb;
    import big_core_dmem_arb_pkg::*;

    localparam logic [31:0] FLOOR = 32'h0001_0000;
    localparam logic [31:0] ROOF  = 32'h0001_FFFF;

    logic          clk, rst;
    logic          core_v, fab_v;
    t_core2mem_req core_req, fab_req;
    logic [31:0]   rd_data;

    logic [2:0]  core_rdy, fab_rdy, core_rsp_v, fab_rsp_v, oor_err;
    logic [31:0] core_rsp_d [3];
    logic [31:0] fab_rsp_d  [3];
    logic [69:0] mem_req_w  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        big_core_dmem_arb #(
            .RD_LATENCY  (g + 1),
            .REGION_FLOOR(FLOOR),
            .REGION_ROOF (ROOF)
        ) u_dut (
            .Clk         (clk),
            .Rst         (rst),
            .CoreReqValid(core_v),
            .CoreReq     (core_req),
            .CoreReqReady(core_rdy[g]),
            .CoreRspValid(core_rsp_v[g]),
            .CoreRspData (core_rsp_d[g]),
            .FabReqValid (fab_v),
            .FabReq      (fab_req),
            .FabReqReady (fab_rdy[g]),
            .FabRspValid (fab_rsp_v[g]),
            .FabRspData  (fab_rsp_d[g]),
            .MemReq      (mem_req_w[g]),
            .MemRdData   (rd_data),
            .OorErr      (oor_err[g])
        );
    end

    always #5 clk = ~clk;

    // Reference model: preference, sticky error and a list of responses due per latency.
    typedef struct {
        int due;
        int lat;
        bit owner;
        bit oor;
    } exp_t;

    exp_t exp_q[$];
    bit   m_pref_core;
    bit   m_oor;
    int   cyc;
    int   total;
    int   bad;

    function automatic bit in_region(input logic [31:0] a);
        return (a >= FLOOR) && (a <= ROOF);
    endfunction

    function automatic int winner();
        bit cl, fl;
        cl = core_v && (core_req.wr_en || core_req.rd_en);
        fl = fab_v && (fab_req.wr_en || fab_req.rd_en);
        if (cl && fl) return m_pref_core ? 1 : 2;
        if (cl) return 1;
        if (fl) return 2;
        return 0;
    endfunction

    function automatic bit exp_core_rdy();
        return core_v && (!(core_req.wr_en || core_req.rd_en) || winner() == 1);
    endfunction

    function automatic bit exp_fab_rdy();
        return fab_v && (!(fab_req.wr_en || fab_req.rd_en) || winner() == 2);
    endfunction

    function automatic t_core2mem_req exp_mem();
        t_core2mem_req r;
        int w;
        bit inr;
        r = '0;
        w = winner();
        if (w != 0) begin
            r = (w == 1) ? core_req : fab_req;
            inr = in_region(r.address);
            r.address = r.address - FLOOR;
            if (!inr) begin
                r.wr_en = 1'b0;
                r.rd_en = 1'b0;
            end else if (r.wr_en) begin
                r.rd_en = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic void exp_rsp(input int g, output bit cv, output bit fv, output logic [31:0] d);
        cv = 1'b0;
        fv = 1'b0;
        d  = '0;
        foreach (exp_q[i]) begin
            if (exp_q[i].lat == g + 1 && exp_q[i].due == cyc) begin
                if (exp_q[i].owner) fv = 1'b1;
                else cv = 1'b1;
                d = exp_q[i].oor ? 32'h0 : rd_data;
            end
        end
    endfunction

    task automatic model_clear();
        m_pref_core = 1'b1;
        m_oor       = 1'b0;
        exp_q.delete();
    endtask

    // Advance the model with the inputs present at this edge, then move to the next mid-cycle.
    task automatic next_cycle();
        int w;
        t_core2mem_req r;
        bit oor;
        w = winner();
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].due <= cyc) exp_q.delete(i);
        end
        if (w != 0 && !rst) begin
            r = (w == 1) ? core_req : fab_req;
            oor = !in_region(r.address);
            m_pref_core = (w == 2);
            if (oor) m_oor = 1'b1;
            if (r.rd_en && !r.wr_en) begin
                for (int l = 1; l <= 3; l++) begin
                    exp_q.push_back('{due: cyc + l, lat: l, owner: (w == 2), oor: oor});
                end
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        core_v   = 1'b0;
        fab_v    = 1'b0;
        core_req = '0;
        fab_req  = '0;
    endtask

    function automatic t_core2mem_req mk_req(input logic [31:0] a, input bit wr, input bit rd);
        t_core2mem_req r;
        r.address = a;
        r.wr_data = $urandom();
        r.byte_en = 4'hF;
        r.wr_en   = wr;
        r.rd_en   = rd;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_idle();
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        model_clear();
        rd_data = 32'h1234_5678;
        repeat (2) @(negedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            total++;
            if ({core_rdy[g], fab_rdy[g], core_rsp_v[g], fab_rsp_v[g], oor_err[g]} !== 5'b0) begin
                bad++;
                $display("FAIL reset_flags g=%0d got=%b exp=00000", g,
                         {core_rdy[g], fab_rdy[g], core_rsp_v[g], fab_rsp_v[g], oor_err[g]});
            end
            total++;
            if (core_rsp_d[g] !== 32'h0 || fab_rsp_d[g] !== 32'h0 || mem_req_w[g] !== 70'h0) begin
                bad++;
                $display("FAIL reset_data g=%0d core=%h fab=%h mem=%h exp=0", g,
                         core_rsp_d[g], fab_rsp_d[g], mem_req_w[g]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_core_read();
        t_core2mem_req m;
        do_reset();
        core_v   = 1'b1;
        core_req = mk_req(32'h0001_0010, 1'b0, 1'b1);
        rd_data  = 32'h0;
        #1;
        m = t_core2mem_req'(mem_req_w[0]);
        total++;
        if (core_rdy[0] !== 1'b1 || m.address !== 32'h10 || m.rd_en !== 1'b1 || m.wr_en !== 1'b0) begin
            bad++;
            $display("FAIL core_read_issue rdy=%b addr=%h rd=%b wr=%b exp=1/10/1/0",
                     core_rdy[0], m.address, m.rd_en, m.wr_en);
        end
        next_cycle();
        set_idle();
        rd_data = 32'hA5A5_1234;
        #1;
        total++;
        if (core_rsp_v[0] !== 1'b1 || core_rsp_d[0] !== 32'hA5A5_1234 || fab_rsp_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL core_read_rsp v=%b d=%h fabv=%b exp=1/a5a51234/0",
                     core_rsp_v[0], core_rsp_d[0], fab_rsp_v[0]);
        end
        next_cycle();
        #1;
        total++;
        if (core_rsp_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL core_read_one_shot v=%b exp=0", core_rsp_v[0]);
        end
    endtask

    task automatic test_back_to_back();
        int nc [3];
        int nf [3];
        do_reset();
        for (int g = 0; g < 3; g++) begin
            nc[g] = 0;
            nf[g] = 0;
        end
        core_req = mk_req(32'h0001_0100, 1'b0, 1'b1);
        fab_req  = mk_req(32'h0001_0200, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            core_v  = (i < 6);
            fab_v   = (i < 6);
            rd_data = $urandom();
            #1;
            for (int g = 0; g < 3; g++) begin
                if (i < 6) begin
                    total++;
                    if (core_rdy[g] !== (i % 2 == 0) || fab_rdy[g] !== (i % 2 == 1)) begin
                        bad++;
                        $display("FAIL alt_grant g=%0d i=%0d core=%b fab=%b exp_core=%0d",
                                 g, i, core_rdy[g], fab_rdy[g], (i % 2 == 0));
                    end
                end
                if (core_rsp_v[g] === 1'b1) nc[g]++;
                if (fab_rsp_v[g] === 1'b1) nf[g]++;
                if (core_rsp_v[g] === 1'b1 || fab_rsp_v[g] === 1'b1) begin
                    total++;
                    if ((core_rsp_v[g] & fab_rsp_v[g]) !== 1'b0 ||
                        (core_rsp_d[g] | fab_rsp_d[g]) !== rd_data) begin
                        bad++;
                        $display("FAIL alt_rsp g=%0d i=%0d cd=%h fd=%h exp=%h",
                                 g, i, core_rsp_d[g], fab_rsp_d[g], rd_data);
                    end
                end
            end
            next_cycle();
        end
        for (int g = 0; g < 3; g++) begin
            total++;
            if (nc[g] != 3 || nf[g] != 3) begin
                bad++;
                $display("FAIL alt_counts g=%0d core=%0d fab=%0d exp=3/3", g, nc[g], nf[g]);
            end
        end
    endtask

    task automatic test_oor_write();
        t_core2mem_req m;
        do_reset();
        fab_v   = 1'b1;
        fab_req = mk_req(32'h0000_0100, 1'b1, 1'b0);
        #1;
        m = t_core2mem_req'(mem_req_w[0]);
        total++;
        if (fab_rdy[0] !== 1'b1 || m.wr_en !== 1'b0 || m.rd_en !== 1'b0 || oor_err[0] !== 1'b0) begin
            bad++;
            $display("FAIL oor_wr_issue rdy=%b wr=%b rd=%b err=%b exp=1/0/0/0",
                     fab_rdy[0], m.wr_en, m.rd_en, oor_err[0]);
        end
        next_cycle();
        set_idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (oor_err !== 3'b111 || core_rsp_v !== 3'b0 || fab_rsp_v !== 3'b0) begin
                bad++;
                $display("FAIL oor_wr_sticky i=%0d err=%b crv=%b frv=%b exp=111/000/000",
                         i, oor_err, core_rsp_v, fab_rsp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_oor_read();
        do_reset();
        core_v   = 1'b1;
        core_req = mk_req(32'h00FE_0000, 1'b0, 1'b1);
        rd_data  = 32'hDEAD_BEEF;
        next_cycle();
        set_idle();
        #1;
        total++;
        if (core_rsp_v[1] !== 1'b0) begin
            bad++;
            $display("FAIL oor_rd_early v=%b exp=0", core_rsp_v[1]);
        end
        next_cycle();
        #1;
        total++;
        if (core_rsp_v[1] !== 1'b1 || core_rsp_d[1] !== 32'h0 || fab_rsp_v[1] !== 1'b0) begin
            bad++;
            $display("FAIL oor_rd_rsp v=%b d=%h fabv=%b exp=1/0/0", core_rsp_v[1], core_rsp_d[1], fab_rsp_v[1]);
        end
        next_cycle();
    endtask

    task automatic test_latency3();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_idle();
            if (i == 0 || i == 2) begin
                core_v   = 1'b1;
                core_req = mk_req(32'h0001_0000 + 32'(i * 4), 1'b0, 1'b1);
            end else if (i == 1) begin
                fab_v   = 1'b1;
                fab_req = mk_req(32'h0001_FFFC, 1'b0, 1'b1);
            end
            rd_data = $urandom();
            #1;
            total++;
            if (core_rsp_v[2] !== (i == 3 || i == 5) || fab_rsp_v[2] !== (i == 4)) begin
                bad++;
                $display("FAIL lat3_timing i=%0d core=%b fab=%b", i, core_rsp_v[2], fab_rsp_v[2]);
            end
            if (i >= 3 && i <= 5) begin
                total++;
                if ((core_rsp_d[2] | fab_rsp_d[2]) !== rd_data) begin
                    bad++;
                    $display("FAIL lat3_data i=%0d got=%h exp=%h", i, core_rsp_d[2] | fab_rsp_d[2], rd_data);
                end
            end
            next_cycle();
        end
    endtask

    function automatic t_core2mem_req rand_req();
        t_core2mem_req r;
        int k;
        int a;
        a = $urandom_range(0, 11);
        case (a)
            0:       r.address = $urandom();
            1:       r.address = FLOOR - 32'h1;
            2:       r.address = ROOF;
            3:       r.address = ROOF + 32'h1;
            4:       r.address = FLOOR;
            default: r.address = FLOOR | ($urandom() & 32'h0000_FFFF);
        endcase
        r.wr_data = $urandom();
        r.byte_en = 4'($urandom());
        k = $urandom_range(0, 9);
        r.wr_en = (k >= 6);
        r.rd_en = (k >= 1 && k <= 5) || (k == 9);
        return r;
    endfunction

    task automatic test_random();
        t_core2mem_req em, m;
        bit ecr, efr, cv, fv, acc_c, acc_f;
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!core_v && $urandom_range(0, 3) != 0) begin
                core_v   = 1'b1;
                core_req = rand_req();
            end
            if (!fab_v && $urandom_range(0, 3) != 0) begin
                fab_v   = 1'b1;
                fab_req = rand_req();
            end
            rd_data = $urandom();
            #1;
            ecr = exp_core_rdy();
            efr = exp_fab_rdy();
            em  = exp_mem();
            for (int g = 0; g < 3; g++) begin
                m = t_core2mem_req'(mem_req_w[g]);
                exp_rsp(g, cv, fv, d);
                total++;
                if (core_rdy[g] !== ecr || fab_rdy[g] !== efr) begin
                    bad++;
                    $display("FAIL rnd_ready g=%0d i=%0d got=%b%b exp=%b%b", g, i, core_rdy[g], fab_rdy[g], ecr, efr);
                end
                total++;
                if (m !== em) begin
                    bad++;
                    $display("FAIL rnd_memreq g=%0d i=%0d got=%h exp=%h", g, i, m, em);
                end
                total++;
                if (core_rsp_v[g] !== cv || fab_rsp_v[g] !== fv ||
                    core_rsp_d[g] !== (cv ? d : 32'h0) || fab_rsp_d[g] !== (fv ? d : 32'h0)) begin
                    bad++;
                    $display("FAIL rnd_rsp g=%0d i=%0d got=%b%b %h %h exp=%b%b %h", g, i,
                             core_rsp_v[g], fab_rsp_v[g], core_rsp_d[g], fab_rsp_d[g], cv, fv, d);
                end
                total++;
                if (oor_err[g] !== m_oor) begin
                    bad++;
                    $display("FAIL rnd_oor g=%0d i=%0d got=%b exp=%b", g, i, oor_err[g], m_oor);
                end
            end
            acc_c = core_v && ecr;
            acc_f = fab_v && efr;
            next_cycle();
            if (acc_c) core_v = 1'b0;
            if (acc_f) fab_v = 1'b0;
        end
        set_idle();
        repeat (4) next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        core_v   = 1'b1;
        core_req = mk_req(32'h0001_0040, 1'b0, 1'b1);
        fab_v    = 1'b1;
        fab_req  = mk_req(32'h0000_0000, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        set_idle();
        core_v   = 1'b1;
        core_req = mk_req(32'h0001_0080, 1'b0, 1'b1);
        next_cycle();
        set_idle();
        rst = 1'b1;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (core_rsp_v !== 3'b0 || fab_rsp_v !== 3'b0 || oor_err !== 3'b0) begin
                bad++;
                $display("FAIL rst_mid_quiet i=%0d crv=%b frv=%b err=%b exp=0", i, core_rsp_v, fab_rsp_v, oor_err);
            end
            next_cycle();
        end
        rst = 1'b0;
        core_v   = 1'b1;
        core_req = mk_req(32'h0001_0000, 1'b0, 1'b1);
        fab_v    = 1'b1;
        fab_req  = mk_req(32'h0001_0004, 1'b0, 1'b1);
        #1;
        total++;
        if (core_rdy !== 3'b111 || fab_rdy !== 3'b000) begin
            bad++;
            $display("FAIL rst_mid_pref core=%b fab=%b exp=111/000", core_rdy, fab_rdy);
        end
        next_cycle();
        set_idle();
        repeat (4) next_cycle();
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        rd_data = '0;
        cyc     = 0;
        total   = 0;
        bad     = 0;
        set_idle();
        model_clear();
        test_reset();
        test_core_read();
        test_back_to_back();
        test_oor_write();
        test_oor_read();
        test_latency3();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
